// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Serialises the instruction-fetch port (A) and the MEM-stage data port (B)
// onto one shared memory port. A three-state grant FSM owns the shared port
// for one transaction at a time, and always returns through IDLE afterwards.
// Read data is broadcast to both ports. The matching resp qualifies it.
//
// Build option: define MEM_ARB_ROUND_ROBIN_EN to break simultaneous requests
// round-robin, using a last_served register. If it is left undefined, port B
// wins every tie. In that case port A can starve while port B keeps
// requesting.

module mem_port_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        read_a,
    input  logic        write_a,
    input  logic [1:0]  wmask_a,
    input  logic [15:0] address_a,
    input  logic [15:0] wdata_a,
    output logic        resp_a,
    output logic [15:0] rdata_a,
    input  logic        read_b,
    input  logic        write_b,
    input  logic [1:0]  wmask_b,
    input  logic [15:0] address_b,
    input  logic [15:0] wdata_b,
    output logic        resp_b,
    output logic [15:0] rdata_b,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [1:0]  pmem_wmask,
    output logic [15:0] pmem_address,
    output logic [15:0] pmem_wdata,
    input  logic        pmem_resp,
    input  logic [15:0] pmem_rdata,
    output logic        grant_a,
    output logic        grant_b
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SERVE_A = 2'b01,
        SERVE_B = 2'b10
    } state_t;

    state_t state_r;
    state_t state_s;
    logic   req_a_s;
    logic   req_b_s;
    logic   tie_pick_b_s;
    logic   grant_a_r;
    logic   grant_b_r;

    assign req_a_s = read_a | write_a;
    assign req_b_s = read_b | write_b;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // 1'b0 means A was served last, 1'b1 means B was served last
    logic last_served_r;

    // Record the port of each completed transaction so that the other port wins the next tie
    always_ff @(posedge clk) begin
        if (reset) begin
            last_served_r <= 1'b0;
        end else if (pmem_resp && (state_r == SERVE_A)) begin
            last_served_r <= 1'b0;
        end else if (pmem_resp && (state_r == SERVE_B)) begin
            last_served_r <= 1'b1;
        end else begin
            last_served_r <= last_served_r;
        end
    end

    assign tie_pick_b_s = ~last_served_r;
`else
    assign tie_pick_b_s = 1'b1;
`endif

    // Grant state register; a reset abandons any in-flight access
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            grant_a_r <= 1'b0;
            grant_b_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            grant_a_r <= (state_s == SERVE_A);
            grant_b_r <= (state_s == SERVE_B);
        end
    end

    // Next-state selection: arbitrate from IDLE, hold until pmem_resp, then return to IDLE
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_a_s && req_b_s) begin
                    state_s = tie_pick_b_s ? SERVE_B : SERVE_A;
                end else if (req_b_s) begin
                    state_s = SERVE_B;
                end else if (req_a_s) begin
                    state_s = SERVE_A;
                end else begin
                    state_s = IDLE;
                end
            end
            SERVE_A: begin
                if (pmem_resp) begin
                    state_s = IDLE;
                end else begin
                    state_s = SERVE_A;
                end
            end
            SERVE_B: begin
                if (pmem_resp) begin
                    state_s = IDLE;
                end else begin
                    state_s = SERVE_B;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Shared-port mux: pass the owning port through, drive zeros when no one owns it
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_wmask   = 2'b00;
        pmem_address = 16'h0000;
        pmem_wdata   = 16'h0000;
        resp_a       = 1'b0;
        resp_b       = 1'b0;
        case (state_r)
            SERVE_A: begin
                pmem_read    = read_a;
                pmem_write   = write_a;
                pmem_wmask   = wmask_a;
                pmem_address = address_a;
                pmem_wdata   = wdata_a;
                resp_a       = pmem_resp;
            end
            SERVE_B: begin
                pmem_read    = read_b;
                pmem_write   = write_b;
                pmem_wmask   = wmask_b;
                pmem_address = address_b;
                pmem_wdata   = wdata_b;
                resp_b       = pmem_resp;
            end
            default: begin
                pmem_read    = 1'b0;
                pmem_write   = 1'b0;
                pmem_wmask   = 2'b00;
                pmem_address = 16'h0000;
                pmem_wdata   = 16'h0000;
                resp_a       = 1'b0;
                resp_b       = 1'b0;
            end
        endcase
    end

    assign rdata_a = pmem_rdata;
    assign rdata_b = pmem_rdata;
    assign grant_a = grant_a_r;
    assign grant_b = grant_b_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Inputs change 1 time unit after each rising edge. Outputs are sampled 2 units later.

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        read_a, write_a, read_b, write_b;
    logic [1:0]  wmask_a, wmask_b;
    logic [15:0] address_a, wdata_a, address_b, wdata_b;
    logic        resp_a, resp_b;
    logic [15:0] rdata_a, rdata_b;
    logic        pmem_read, pmem_write;
    logic [1:0]  pmem_wmask;
    logic [15:0] pmem_address, pmem_wdata;
    logic        pmem_resp;
    logic [15:0] pmem_rdata;
    logic        grant_a, grant_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .read_a(read_a), .write_a(write_a), .wmask_a(wmask_a),
        .address_a(address_a), .wdata_a(wdata_a),
        .resp_a(resp_a), .rdata_a(rdata_a),
        .read_b(read_b), .write_b(write_b), .wmask_b(wmask_b),
        .address_b(address_b), .wdata_b(wdata_b),
        .resp_b(resp_b), .rdata_b(rdata_b),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wmask(pmem_wmask),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
        .grant_a(grant_a), .grant_b(grant_b)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        read_a = 1'b0; write_a = 1'b0; wmask_a = 2'b00; address_a = 16'h0000; wdata_a = 16'h0000;
        read_b = 1'b0; write_b = 1'b0; wmask_b = 2'b00; address_b = 16'h0000; wdata_b = 16'h0000;
        pmem_resp = 1'b0; pmem_rdata = 16'h0000;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        clear_inputs();
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        cyc();
        read_a = 1'b1; address_a = 16'hFFFF; write_b = 1'b1; wdata_b = 16'hAAAA; pmem_resp = 1'b1;
        cyc();
        settle();
        checks++; if ({grant_a, grant_b} !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", {grant_a, grant_b}); end
        checks++; if ({pmem_read, pmem_write, pmem_wmask} !== 4'b0000) begin errors++; $display("FAIL reset_strobes: got %b want 0000", {pmem_read, pmem_write, pmem_wmask}); end
        checks++; if ({pmem_address, pmem_wdata} !== 32'h0) begin errors++; $display("FAIL reset_addr_data: got %h want 0", {pmem_address, pmem_wdata}); end
        checks++; if ({resp_a, resp_b} !== 2'b00) begin errors++; $display("FAIL reset_resp: got %b want 00", {resp_a, resp_b}); end
        clear_inputs();
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_single_a_read();
        apply_reset();
        read_a = 1'b1; address_a = 16'h1000;
        settle();
        checks++; if ({grant_a, pmem_read} !== 2'b00) begin errors++; $display("FAIL a_read_req_cycle: got %b want 00", {grant_a, pmem_read}); end
        cyc();
        settle();
        checks++; if ({grant_a, grant_b, pmem_read, pmem_write} !== 4'b1010) begin errors++; $display("FAIL a_read_grant: got %b want 1010", {grant_a, grant_b, pmem_read, pmem_write}); end
        checks++; if (pmem_address !== 16'h1000) begin errors++; $display("FAIL a_read_addr: got %h want 1000", pmem_address); end
        cyc();
        cyc();
        settle();
        checks++; if ({resp_a, grant_a} !== 2'b01) begin errors++; $display("FAIL a_read_wait: got %b want 01", {resp_a, grant_a}); end
        cyc();
        pmem_resp = 1'b1; pmem_rdata = 16'hBEEF;
        settle();
        checks++; if ({resp_a, resp_b} !== 2'b10) begin errors++; $display("FAIL a_read_resp: got %b want 10", {resp_a, resp_b}); end
        checks++; if (rdata_a !== 16'hBEEF) begin errors++; $display("FAIL a_read_rdata: got %h want beef", rdata_a); end
        checks++; if (rdata_b !== 16'hBEEF) begin errors++; $display("FAIL b_rdata_broadcast: got %h want beef", rdata_b); end
        cyc();
        read_a = 1'b0; pmem_resp = 1'b0;
        settle();
        checks++; if ({resp_a, grant_a, pmem_read} !== 3'b000) begin errors++; $display("FAIL a_read_done: got %b want 000", {resp_a, grant_a, pmem_read}); end
        cyc();
    endtask

    task automatic test_tie_first();
        apply_reset();
        read_a = 1'b1; address_a = 16'h0040;
        write_b = 1'b1; address_b = 16'h2000; wdata_b = 16'h1234; wmask_b = 2'b01;
        cyc();
        settle();
        checks++; if ({grant_a, grant_b, pmem_read, pmem_write} !== 4'b0101) begin errors++; $display("FAIL tie_b_first: got %b want 0101", {grant_a, grant_b, pmem_read, pmem_write}); end
        checks++; if ({pmem_address, pmem_wdata, pmem_wmask} !== {16'h2000, 16'h1234, 2'b01}) begin errors++; $display("FAIL tie_b_payload: got %h %h %b", pmem_address, pmem_wdata, pmem_wmask); end
        pmem_resp = 1'b1;
        settle();
        checks++; if ({resp_a, resp_b} !== 2'b01) begin errors++; $display("FAIL tie_b_resp: got %b want 01", {resp_a, resp_b}); end
        cyc();
        write_b = 1'b0; pmem_resp = 1'b0;
        settle();
        checks++; if ({grant_a, grant_b, pmem_read, pmem_write} !== 4'b0000) begin errors++; $display("FAIL tie_idle_gap: got %b want 0000", {grant_a, grant_b, pmem_read, pmem_write}); end
        cyc();
        settle();
        checks++; if ({grant_a, grant_b, pmem_read} !== 3'b101 || pmem_address !== 16'h0040) begin errors++; $display("FAIL tie_a_second: got %b addr %h want 101 addr 0040", {grant_a, grant_b, pmem_read}, pmem_address); end
        pmem_resp = 1'b1;
        cyc();
        read_a = 1'b0; pmem_resp = 1'b0;
        cyc();
    endtask

    task automatic test_contention();
        int         n_b_done = 0;
        int         n_grants = 0;
        logic       a_done = 1'b0;
        logic [3:0] order = 4'b0000;
        logic [3:0] expected;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        expected = 4'b1011;
`else
        expected = 4'b1110;
`endif
        apply_reset();
        read_a = 1'b1; address_a = 16'h0100;
        write_b = 1'b1; address_b = 16'h3000; wdata_b = 16'h0001; wmask_b = 2'b11;
        for (int cy = 0; cy < 40 && n_grants < 4; cy++) begin
            cyc();
            pmem_resp = 1'b0;
            if (n_b_done == 3) write_b = 1'b0;
            if (a_done) read_a = 1'b0;
            if (grant_a && grant_b) begin
                checks++; errors++; $display("FAIL contention_exclusive: both grants high");
            end
            if (grant_b) begin
                order = {order[2:0], 1'b1}; n_grants++; n_b_done++; pmem_resp = 1'b1;
            end else if (grant_a) begin
                order = {order[2:0], 1'b0}; n_grants++; a_done = 1'b1; pmem_resp = 1'b1;
            end
        end
        checks++; if (n_grants != 4) begin errors++; $display("FAIL contention_count: got %0d grants want 4", n_grants); end
        checks++; if (order !== expected) begin errors++; $display("FAIL contention_order: got %b want %b (1=B)", order, expected); end
        cyc();
        clear_inputs();
        cyc();
    endtask

    task automatic test_reset_mid_txn();
        apply_reset();
        write_b = 1'b1; address_b = 16'h4444; wdata_b = 16'h5555; wmask_b = 2'b10;
        cyc();
        settle();
        checks++; if ({grant_b, pmem_write} !== 2'b11) begin errors++; $display("FAIL rst_mid_serving: got %b want 11", {grant_b, pmem_write}); end
        reset = 1'b1;
        cyc();
        reset = 1'b0; write_b = 1'b0;
        settle();
        checks++; if ({grant_a, grant_b, pmem_write} !== 3'b000) begin errors++; $display("FAIL rst_mid_dropped: got %b want 000", {grant_a, grant_b, pmem_write}); end
        cyc();
        cyc();
        pmem_resp = 1'b1;
        settle();
        checks++; if ({resp_a, resp_b} !== 2'b00) begin errors++; $display("FAIL rst_mid_late_resp: got %b want 00", {resp_a, resp_b}); end
        cyc();
        pmem_resp = 1'b0;
        settle();
        checks++; if ({grant_a, grant_b} !== 2'b00) begin errors++; $display("FAIL rst_mid_stays_idle: got %b want 00", {grant_a, grant_b}); end
        cyc();
    endtask

    task automatic test_spurious_resp();
        apply_reset();
        pmem_resp = 1'b1; pmem_rdata = 16'h7777;
        settle();
        checks++; if ({resp_a, resp_b} !== 2'b00) begin errors++; $display("FAIL spurious_resp: got %b want 00", {resp_a, resp_b}); end
        cyc();
        settle();
        checks++; if ({grant_a, grant_b, resp_a, resp_b} !== 4'b0000) begin errors++; $display("FAIL spurious_idle: got %b want 0000", {grant_a, grant_b, resp_a, resp_b}); end
        pmem_resp = 1'b0;
        cyc();
    endtask

    task automatic test_zero_wait();
        apply_reset();
        write_a = 1'b1; address_a = 16'h0ABC; wdata_a = 16'hCAFE; wmask_a = 2'b11;
        cyc();
        pmem_resp = 1'b1;
        settle();
        checks++; if ({grant_a, pmem_write, resp_a, resp_b} !== 4'b1110) begin errors++; $display("FAIL zero_wait_resp: got %b want 1110", {grant_a, pmem_write, resp_a, resp_b}); end
        checks++; if ({pmem_wdata, pmem_wmask} !== {16'hCAFE, 2'b11}) begin errors++; $display("FAIL zero_wait_payload: got %h %b want cafe 11", pmem_wdata, pmem_wmask); end
        cyc();
        write_a = 1'b0; pmem_resp = 1'b0;
        settle();
        checks++; if ({grant_a, resp_a} !== 2'b00) begin errors++; $display("FAIL zero_wait_one_cycle: got %b want 00", {grant_a, resp_a}); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_single_a_read();
        test_tie_first();
        test_contention();
        test_reset_mid_txn();
        test_spurious_resp();
        test_zero_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the pipeline's two memory ports onto one shared physical memory port. Port A carries instruction fetch and port B carries MEM-stage data. The block sits between the CPU datapath's port A/B signals and the single memory (or L2) interface. A small grant FSM serialises transactions. Read data and per-port responses are routed back to the winning requester.

## Interface
Parameters: none. Word width is fixed at 16 bits (lc3b_word).

- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- read_a, write_a  in  1 each  port A strobes, held until resp_a
- wmask_a  in  2  port A byte mask
- address_a, wdata_a  in  16 each  port A address / write data
- resp_a  out  1  port A transaction complete
- rdata_a  out  16  port A read data
- read_b, write_b, wmask_b, address_b, wdata_b, resp_b, rdata_b: same as port A, for port B
- pmem_read, pmem_write  out  1 each  shared-port strobes
- pmem_wmask  out  2  shared-port byte mask
- pmem_address, pmem_wdata  out  16 each  shared-port address / write data
- pmem_resp  in  1  shared-port completion
- pmem_rdata  in  16  shared-port read data
- grant_a, grant_b  out  1 each  registered; high while that port owns pmem

## Operation
- States: IDLE, SERVE_A, SERVE_B. State is held in a register; reset forces IDLE.
- Request: req_a = read_a | write_a, and likewise for req_b.
- In IDLE:
  - Only req_a → SERVE_A.
  - Only req_b → SERVE_B.
  - Both → priority rule (see Configuration).
  - Neither → stay in IDLE.
- In SERVE_x:
  - pmem_read = read_x, pmem_write = write_x.
  - pmem_address, pmem_wdata and pmem_wmask pass through from port x combinationally.
- In SERVE_x with pmem_resp = 1: resp_x = 1 in the same cycle, and the next state is IDLE.
- In SERVE_x with pmem_resp = 0: stay in SERVE_x.
- In IDLE: pmem_read = pmem_write = 0, and pmem_address, pmem_wdata and pmem_wmask are 0.
- rdata_a = rdata_b = pmem_rdata at all times. The data is only meaningful when the matching resp is high.
- resp_a = pmem_resp & (state == SERVE_A). resp_b is defined the same way for SERVE_B.
- pmem_resp in IDLE is ignored; it causes no resp and no state change.
- grant_a = (state == SERVE_A) and grant_b = (state == SERVE_B). The two are never high together.
- Requester contract:
  - Strobes, address, wdata and wmask stay stable from assertion until resp.
  - read and write are never both high.
  - Violations are outside the contract.
- Reset mid-transaction: the next state is IDLE and the strobes drop. The in-flight memory access is abandoned, and a late pmem_resp is ignored.

## Timing
- A request first seen high in cycle t is granted at the edge ending t. pmem strobes are high from cycle t+1.
- pmem_resp in cycle t+1+k gives resp_x in cycle t+1+k. The minimum request-to-resp time is 1 cycle plus memory latency.
- After each completion there is exactly one IDLE cycle, so back-to-back transactions are spaced at least 1 cycle apart.
- A requester that sees resp in cycle c and drops its strobe in c+1 is not re-granted.
- Output values on reset:
  - grant_a = grant_b = 0.
  - pmem_read = pmem_write = 0.
  - resp_a = resp_b = 0.
  - pmem_address = pmem_wdata = 0, pmem_wmask = 0.
- Round-robin pointer reset value: last_served = A.

## Configuration
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last_served register updates on every completion.
  - On a simultaneous request, the port not last served wins.
  - Because the reset value is A, B wins the first tie.
  - A reset during a transaction leaves last_served unchanged except that reset forces it to A.
- Undefined:
  - Fixed priority: port B (data) always wins ties.
  - No last_served register exists.
  - Port A can starve while port B requests continuously.

## Test plan
- Single A read: read_a=1, address_a=0x1000; memory responds 3 cycles after pmem_read rises with 0xBEEF.
  - pmem_read and grant_a go high 1 cycle after the request, with pmem_address=0x1000.
  - resp_a pulses for 1 cycle with rdata_a=0xBEEF; resp_b stays 0.
- Tie, first round: A read at 0x0040 and B write at 0x2000 (data 0x1234, wmask 01) asserted in the same cycle.
  - B is served first: pmem_write=1, pmem_wdata=0x1234, pmem_wmask=01.
  - Then 1 IDLE cycle, then A with pmem_read and pmem_address=0x0040. Both builds must show this order.
- Sustained contention: A is held on one read while B issues 3 writes back-to-back, each re-asserted the cycle after its resp.
  - With the macro, grant order is B, A, B, B.
  - Without the macro, grant order is B, B, B, A.
- Reset during SERVE_B before pmem_resp: reset is high for 1 cycle.
  - The next cycle has grant_b=0 and pmem_write=0.
  - A pmem_resp 2 cycles later produces neither resp_a nor resp_b.
- Spurious pmem_resp in IDLE with no requests: resp_a=resp_b=0 and the state stays IDLE.
- Zero-wait memory, where pmem_resp is high in the first SERVE cycle: resp_x arrives 1 cycle after the request, and grant_x is high for exactly 1 cycle.
